// File: rtl/f0_period_meter.sv
// Conditions the raw firefly pulse f0 (2-flop sync + run-length glitch filter) and measures
// its period and high time in clk cycles, with lock and loss-of-signal reporting.
module f0_period_meter #(
   parameter int CNT_W    = 20,
   parameter int FILT_LEN = 4,
   parameter int TIMEOUT  = 200000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             f0,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             lock,
   output logic             timeout
);

   localparam int RUN_W = $clog2(FILT_LEN + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   if (64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
      $error("TIMEOUT must be smaller than 2**CNT_W");
   end

   typedef enum logic [0:0] {IDLE, MEASURE} state_t;

   logic [1:0]       sync_q;
   logic             filt_q, filt_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             rise_q, fall_q;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q, hcnt_q;
   logic             fall_seen_q, armed_q;
   logic [CNT_W-1:0] period_q, high_q;
   logic             valid_q, lock_q, timeout_q;

   // Level flips only after FILT_LEN consecutive disagreeing samples.
   always_comb begin
      filt_d = filt_q;
      run_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (run_q == RUN_W'(FILT_LEN - 1)) filt_d = ~filt_q;
         else                               run_d  = run_q + RUN_W'(1);
      end
   end

   // Edges are registered from the next-state level so rise and fall see equal delay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         filt_q <= 1'b0;
         run_q  <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], f0};
         filt_q <= filt_d;
         run_q  <= run_d;
         rise_q <= filt_d & ~filt_q;
         fall_q <= ~filt_d & filt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hcnt_q      <= '0;
         fall_seen_q <= 1'b0;
         armed_q     <= 1'b1;
         period_q    <= '0;
         high_q      <= '0;
         valid_q     <= 1'b0;
         lock_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rise_q) begin
                  state_q     <= MEASURE;
                  cnt_q       <= '0;
                  hcnt_q      <= CNT_W'(1);
                  fall_seen_q <= 1'b0;
                  armed_q     <= 1'b1;
               end else if (armed_q) begin
                  // Disarms after one strobe so a long loss reports only once.
                  if (cnt_q == TO_LAST) begin
                     timeout_q <= 1'b1;
                     lock_q    <= 1'b0;
                     armed_q   <= 1'b0;
                     cnt_q     <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            MEASURE: begin
               if (rise_q) begin
                  period_q    <= cnt_q + CNT_W'(1);
                  high_q      <= fall_seen_q ? hcnt_q : cnt_q + CNT_W'(1);
                  valid_q     <= 1'b1;
                  lock_q      <= 1'b1;
                  cnt_q       <= '0;
                  hcnt_q      <= CNT_W'(1);
                  fall_seen_q <= 1'b0;
               end else if (cnt_q == TO_LAST) begin
                  timeout_q <= 1'b1;
                  lock_q    <= 1'b0;
                  armed_q   <= 1'b0;
                  state_q   <= IDLE;
                  cnt_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (fall_q) fall_seen_q <= 1'b1;
                  if (filt_q && !fall_seen_q) hcnt_q <= hcnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign period    = period_q;
   assign high_time = high_q;
   assign valid     = valid_q;
   assign lock      = lock_q;
   assign timeout   = timeout_q;

endmodule
